// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions, digit glyphs and the undecodable-digit code
package seg7_pkg;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;
  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);
  localparam logic [6:0] SEG_GLYPH_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] SEG_GLYPH_1 = M_B | M_C;
  localparam logic [6:0] SEG_GLYPH_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] SEG_GLYPH_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] SEG_GLYPH_4 = M_B | M_C | M_F | M_G;
  localparam logic [6:0] SEG_GLYPH_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_GLYPH_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_GLYPH_7 = M_A | M_B | M_C;
  localparam logic [6:0] SEG_GLYPH_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_GLYPH_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [3:0] BCD_INVALID = 4'hF;
endpackage

// File: rtl/segment_pattern_decoder.sv
// segment_pattern_decoder: maps a 7-segment pattern back to its BCD digit
module segment_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       invalid
);
  // glyph lookup; anything that is not exactly a 0-9 glyph is flagged invalid
  always_comb begin
    {invalid, bcd} = seg == SEG_GLYPH_0 ? {1'b0, 4'd0} :
                     seg == SEG_GLYPH_1 ? {1'b0, 4'd1} :
                     seg == SEG_GLYPH_2 ? {1'b0, 4'd2} :
                     seg == SEG_GLYPH_3 ? {1'b0, 4'd3} :
                     seg == SEG_GLYPH_4 ? {1'b0, 4'd4} :
                     seg == SEG_GLYPH_5 ? {1'b0, 4'd5} :
                     seg == SEG_GLYPH_6 ? {1'b0, 4'd6} :
                     seg == SEG_GLYPH_7 ? {1'b0, 4'd7} :
                     seg == SEG_GLYPH_8 ? {1'b0, 4'd8} :
                     seg == SEG_GLYPH_9 ? {1'b0, 4'd9} : {1'b1, BCD_INVALID};
  end
endmodule

// File: rtl/segment_frame_reader.sv
// segment_frame_reader: samples a multiplexed 7-segment bus into per-scan BCD frames
module segment_frame_reader
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   an_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [NDIG-1:0]   out_err,
  output logic              overrun
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
  logic [NDIG-1:0]   an_prev, mask, errs;
  logic [CW-1:0]     cnt;
  logic              sampled, changed, onehot, sample, frame_done, invalid;
  logic [4*NDIG-1:0] slots;
  logic [3:0]        bcd;
  assign changed    = an_in != an_prev;
  assign onehot     = an_in != '0 && (an_in & (an_in - 1'b1)) == '0;
  assign sample     = onehot && !changed && cnt == CMAX && !sampled;
  assign frame_done = &mask;
  segment_pattern_decoder u_dec (.seg(seg_in), .bcd(bcd), .invalid(invalid));
  // strobe settle tracker: restart on any strobe change, allow one sample per dwell
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_prev <= '0;
      cnt     <= '0;
      sampled <= 1'b0;
    end else begin
      an_prev <= an_in;
      cnt     <= changed ? '0 : cnt == CMAX ? cnt : cnt + 1'b1;
      sampled <= changed ? 1'b0 : sampled | sample;
    end
  end
  // seen-mask: cleared once the frame completes, a coincident sample starts the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) mask <= '0;
    else mask <= (frame_done ? '0 : mask) | (sample ? an_in : '0);
  end
  for (genvar g = 0; g < NDIG; g++) begin : g_slot
    // per-digit slot: latest decoded value wins until the frame is handed out
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slots[4*g +: 4] <= '0;
        errs[g]         <= 1'b0;
      end else if (sample && an_in[g]) begin
        slots[4*g +: 4] <= bcd;
        errs[g]         <= invalid;
      end
    end
  end
  // output register: load when free or being accepted, otherwise drop and flag overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else if (frame_done && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      out_bcd   <= slots;
      out_err   <= errs;
    end else if (frame_done) begin
      overrun   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_segment_frame_reader.sv
// tb_segment_frame_reader: directed and randomized dwell-based checking of segment_frame_reader
module tb_segment_frame_reader;
  localparam int NDIG = 4;
  localparam int SETTLE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [3:0] an_in = '0;
  logic out_ready = 1'b1;
  logic out_valid, overrun;
  logic [15:0] out_bcd;
  logic [3:0] out_err;
  always #5 clk = ~clk;
  segment_frame_reader #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_err(out_err), .overrun(overrun)
  );
  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  int comp = 0;
  int bad = 0;
  bit m_valid, m_ovr, pend;
  logic [15:0] m_bcd, p_bcd, acc_bcd;
  logic [3:0] m_err, p_err, seen, acc_err, prev_an;
  logic [3:0] s_bcd [4];
  bit s_err [4];
  int acc_cnt = 0;
  int acc0;

  function automatic void decode(input logic [6:0] s, output logic [3:0] b, output bit e);
    b = 4'hF;
    e = 1'b1;
    for (int k = 0; k < 10; k++)
      if (glyph[k] == s) begin
        b = 4'(k);
        e = 1'b0;
      end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; pend = 0; m_bcd = '0; m_err = '0; seen = '0;
    p_bcd = '0; p_err = '0;
    for (int k = 0; k < 4; k++) begin s_bcd[k] = '0; s_err[k] = 0; end
  endtask

  // one clock: drive, note a handshake, advance the model, then compare
  task automatic step(input logic r_n, input logic [3:0] an, input logic [6:0] sg, input logic rdy, input bit smp);
    int d;
    logic [3:0] b;
    bit e;
    rst_n = r_n; an_in = an; seg_in = sg; out_ready = rdy;
    #1;
    if (r_n && out_valid && rdy) begin
      acc_cnt++;
      acc_bcd = out_bcd;
      acc_err = out_err;
    end
    @(posedge clk);
    if (!r_n) model_reset();
    else begin
      if (pend) begin
        if (!m_valid || rdy) begin m_valid = 1; m_bcd = p_bcd; m_err = p_err; end
        else m_ovr = 1;
      end else if (rdy) m_valid = 0;
      pend = 0;
      if (smp) begin
        d = 0;
        for (int k = 0; k < 4; k++) if (an[k]) d = k;
        decode(sg, b, e);
        s_bcd[d] = b; s_err[d] = e; seen[d] = 1'b1;
        if (&seen) begin
          pend = 1; seen = '0;
          for (int k = 0; k < 4; k++) begin p_bcd[4*k +: 4] = s_bcd[k]; p_err[k] = s_err[k]; end
        end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_bcd", 32'(out_bcd), 32'(m_bcd));
    chk("out_err", 32'(out_err), 32'(m_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // a strobe dwell: a one-hot strobe is sampled on its SETTLE-th edge after the change
  task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int len, input int rmode, input int rj);
    logic r;
    for (int j = 0; j < len; j++) begin
      r = rj >= 0 ? logic'(j == rj) : rmode == 2 ? logic'($urandom_range(1, 0)) : logic'(rmode == 1);
      step(1'b1, an, sg, r, $onehot(an) && j == SETTLE);
    end
    prev_an = an;
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input int rmode);
    dwell(4'b0001, glyph[d0], 6, rmode, -1);
    dwell(4'b0010, glyph[d1], 6, rmode, -1);
    dwell(4'b0100, glyph[d2], 6, rmode, -1);
    dwell(4'b1000, glyph[d3], 6, rmode, -1);
  endtask

  task automatic rst1();
    step(1'b0, 4'b0000, 7'b0, 1'b1, 1'b0);
    prev_an = '0;
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    model_reset();
    prev_an = '0;
    rst1();
    rst1();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_bcd", 32'(out_bcd), 32'd0);
    // basic scan 1,2,3,4
    scan(1, 2, 3, 4, 1);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t1_frames", 32'(acc_cnt), 32'd1);
    chk("t1_bcd", 32'(acc_bcd), 32'h4321);
    chk("t1_err", 32'(acc_err), 32'h0);
    // undecodable glyph on digit 2
    dwell(4'b0001, glyph[5], 6, 1, -1);
    dwell(4'b0010, glyph[6], 6, 1, -1);
    dwell(4'b0100, 7'b0000001, 6, 1, -1);
    dwell(4'b1000, glyph[7], 6, 1, -1);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t2_bcd", 32'(acc_bcd), 32'h7F65);
    chk("t2_err", 32'(acc_err), 32'b0100);
    // short dwell and multi-hot strobe never sample
    acc0 = acc_cnt;
    dwell(4'b0001, glyph[8], 3, 1, -1);
    dwell(4'b0011, glyph[8], 10, 1, -1);
    dwell(4'b0010, glyph[0], 6, 1, -1);
    dwell(4'b0100, glyph[1], 6, 1, -1);
    dwell(4'b1000, glyph[2], 6, 1, -1);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t3_no_frame", 32'(acc_cnt), 32'(acc0));
    dwell(4'b0001, glyph[9], 6, 1, -1);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t3_one_frame", 32'(acc_cnt), 32'(acc0 + 1));
    chk("t3_bcd", 32'(acc_bcd), 32'h2109);
    // stalled consumer across two frames
    scan(1, 3, 5, 7, 0);
    dwell(4'b0000, 7'b0, 2, 0, -1);
    scan(2, 4, 6, 8, 0);
    dwell(4'b0000, 7'b0, 2, 0, -1);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_held_bcd", 32'(out_bcd), 32'h7531);
    chk("t4_held_valid", 32'(out_valid), 32'd1);
    acc0 = acc_cnt;
    dwell(4'b0001, 7'b0, 3, 1, -1);
    chk("t4_accepted", 32'(acc_bcd), 32'h7531);
    chk("t4_one_accept", 32'(acc_cnt), 32'(acc0 + 1));
    chk("t4_drained", 32'(out_valid), 32'd0);
    // accept and new frame on the same edge
    dwell(4'b0000, 7'b0, 2, 1, -1);
    acc0 = acc_cnt;
    scan(9, 8, 7, 6, 0);
    dwell(4'b0000, 7'b0, 2, 0, -1);
    dwell(4'b0001, glyph[0], 6, 0, -1);
    dwell(4'b0010, glyph[1], 6, 0, -1);
    dwell(4'b0100, glyph[2], 6, 0, -1);
    dwell(4'b1000, glyph[3], 6, 0, SETTLE + 1);
    chk("t5_no_bubble", 32'(out_valid), 32'd1);
    chk("t5_new_bcd", 32'(out_bcd), 32'h3210);
    chk("t5_first", 32'(acc_bcd), 32'h6789);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t5_accepts", 32'(acc_cnt), 32'(acc0 + 2));
    chk("t5_second", 32'(acc_bcd), 32'h3210);
    // reset mid-frame discards partial data
    dwell(4'b0001, glyph[4], 6, 1, -1);
    dwell(4'b0010, glyph[4], 6, 1, -1);
    rst1();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_bcd", 32'(out_bcd), 32'd0);
    chk("t6_err", 32'(out_err), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    acc0 = acc_cnt;
    dwell(4'b0100, glyph[5], 6, 1, -1);
    dwell(4'b1000, glyph[0], 6, 1, -1);
    dwell(4'b0001, glyph[5], 6, 1, -1);
    dwell(4'b0010, glyph[0], 6, 1, -1);
    dwell(4'b0000, 7'b0, 3, 1, -1);
    chk("t6_frames", 32'(acc_cnt), 32'(acc0 + 1));
    chk("t6_bcd_new", 32'(acc_bcd), 32'h0505);
    // randomized dwells against the model
    for (int n = 0; n < 300; n++) begin
      do an = $urandom_range(99, 0) < 70 ? 4'(1 << $urandom_range(3, 0)) : 4'($urandom);
      while (an == prev_an);
      sg = $urandom_range(99, 0) < 80 ? glyph[$urandom_range(9, 0)] : 7'($urandom);
      dwell(an, sg, int'($urandom_range(8, 2)), 2, -1);
    end
    dwell(prev_an == 4'b0000 ? 4'b0011 : 4'b0000, 7'b0, 4, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, bad);
    $finish;
  end
endmodule
